// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong bank controller:
// bank state encoding, default burst length and bank indices.
package pingpong_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_e;

  localparam int unsigned BURST_LEN_DEF = 80;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Writer may target a bank that is empty or still being filled.
  function automatic logic wr_target_ok(input bank_state_e s);
    return (s == FREE) || (s == FILL);
  endfunction

  function automatic logic rd_target_ok(input bank_state_e s);
    return (s == FULL) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// Producer/consumer handshake and status bundle of pingpong_bank_ctrl.
// master = producer/consumer side, slave = the controller.
interface pingpong_bank_ctrl_if;

  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_bank_en;
  logic       rd_req;
  logic       rd_avail;
  logic [1:0] rd_bank_en;
  logic       rd_data_valid;
  logic       rd_mux_sel;
  logic [3:0] bank_state;
  logic       wr_burst_done;
  logic       rd_burst_done;
  logic       overflow;
  logic       underrun;

  modport master (
    output wr_valid, rd_req,
    input  wr_ready, wr_bank_en, rd_avail, rd_bank_en, rd_data_valid,
           rd_mux_sel, bank_state, wr_burst_done, rd_burst_done,
           overflow, underrun
  );

  modport slave (
    input  wr_valid, rd_req,
    output wr_ready, wr_bank_en, rd_avail, rd_bank_en, rd_data_valid,
           rd_mux_sel, bank_state, wr_burst_done, rd_burst_done,
           overflow, underrun
  );

endinterface

// File: rtl/pp_bank_fsm.sv
// Lifecycle of one buffer bank: FREE -> FILL -> FULL -> DRAIN -> FREE.
// The start/last strobes are already qualified for this bank by the top level.
module pp_bank_fsm
  import pingpong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_start,
  input  logic        wr_last,
  input  logic        rd_start,
  input  logic        rd_last,
  output bank_state_e state_o
);

  bank_state_e state_q;
  bank_state_e state_d;

  // Bank state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: last strobes win over start strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (wr_last) begin
          state_d = FULL;
        end else if (wr_start) begin
          state_d = FILL;
        end else begin
          state_d = FREE;
        end
      end
      FILL: begin
        if (wr_last) begin
          state_d = FULL;
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        if (rd_last) begin
          state_d = FREE;
        end else if (rd_start) begin
          state_d = DRAIN;
        end else begin
          state_d = FULL;
        end
      end
      DRAIN: begin
        if (rd_last) begin
          state_d = FREE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = FREE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Two-bank ping-pong line buffer scheduler: write/read pointers, word counters,
// bank enables and output-mux select. Optional PINGPONG_BANK_CTRL_STATS_EN adds burst/drop counters.
module pingpong_bank_ctrl
  import pingpong_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                clk,
  input  logic                rst,
  pingpong_bank_ctrl_if.slave bus
`ifdef PINGPONG_BANK_CTRL_STATS_EN
  ,
  output logic [15:0]         stat_wr_bursts,
  output logic [15:0]         stat_rd_bursts,
  output logic [15:0]         stat_drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  bank_state_e      st_b0;
  bank_state_e      st_b1;
  bank_state_e      wr_tgt_st;
  bank_state_e      rd_tgt_st;
  logic             wr_ready;
  logic             rd_avail;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_last;
  logic             rd_last;

  logic             wr_sel_q,        wr_sel_d;
  logic             rd_sel_q,        rd_sel_d;
  logic [CNT_W-1:0] wr_cnt_q,        wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q,        rd_cnt_d;
  logic             rd_data_valid_q, rd_data_valid_d;
  logic             rd_mux_sel_q,    rd_mux_sel_d;
  logic             wr_burst_done_q, wr_burst_done_d;
  logic             rd_burst_done_q, rd_burst_done_d;

  assign wr_tgt_st = (wr_sel_q == BANK1) ? st_b1 : st_b0;
  assign rd_tgt_st = (rd_sel_q == BANK1) ? st_b1 : st_b0;
  assign wr_ready  = wr_target_ok(wr_tgt_st);
  assign rd_avail  = rd_target_ok(rd_tgt_st);
  assign wr_acc    = bus.wr_valid & wr_ready;
  assign rd_acc    = bus.rd_req & rd_avail;
  assign wr_last   = wr_acc & (wr_cnt_q == LAST_IDX);
  assign rd_last   = rd_acc & (rd_cnt_q == LAST_IDX);

  pp_bank_fsm u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_acc & (wr_sel_q == BANK0)),
    .wr_last  (wr_last & (wr_sel_q == BANK0)),
    .rd_start (rd_acc & (rd_sel_q == BANK0)),
    .rd_last  (rd_last & (rd_sel_q == BANK0)),
    .state_o  (st_b0)
  );

  pp_bank_fsm u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_acc & (wr_sel_q == BANK1)),
    .wr_last  (wr_last & (wr_sel_q == BANK1)),
    .rd_start (rd_acc & (rd_sel_q == BANK1)),
    .rd_last  (rd_last & (rd_sel_q == BANK1)),
    .state_o  (st_b1)
  );

  // Pointer/counter advance and registered read/done outputs
  always_comb begin
    wr_sel_d        = wr_sel_q;
    wr_cnt_d        = wr_cnt_q;
    rd_sel_d        = rd_sel_q;
    rd_cnt_d        = rd_cnt_q;
    rd_data_valid_d = rd_acc;
    wr_burst_done_d = wr_last;
    rd_burst_done_d = rd_last;
    if (wr_last) begin
      wr_cnt_d = '0;
      wr_sel_d = ~wr_sel_q;
    end else if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1'b1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (rd_last) begin
      rd_cnt_d = '0;
      rd_sel_d = ~rd_sel_q;
    end else if (rd_acc) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1'b1);
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (rd_acc) begin
      rd_mux_sel_d = rd_sel_q;
    end else begin
      rd_mux_sel_d = rd_mux_sel_q;
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_q        <= 1'b0;
      rd_sel_q        <= 1'b0;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      rd_data_valid_q <= 1'b0;
      rd_mux_sel_q    <= 1'b0;
      wr_burst_done_q <= 1'b0;
      rd_burst_done_q <= 1'b0;
    end else begin
      wr_sel_q        <= wr_sel_d;
      rd_sel_q        <= rd_sel_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_mux_sel_q    <= rd_mux_sel_d;
      wr_burst_done_q <= wr_burst_done_d;
      rd_burst_done_q <= rd_burst_done_d;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_avail      = rd_avail;
  assign bus.wr_bank_en    = {wr_acc & (wr_sel_q == BANK1), wr_acc & (wr_sel_q == BANK0)};
  assign bus.rd_bank_en    = {rd_acc & (rd_sel_q == BANK1), rd_acc & (rd_sel_q == BANK0)};
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_mux_sel    = rd_mux_sel_q;
  assign bus.bank_state    = {st_b1, st_b0};
  assign bus.wr_burst_done = wr_burst_done_q;
  assign bus.rd_burst_done = rd_burst_done_q;
  assign bus.overflow      = bus.wr_valid & ~wr_ready;
  assign bus.underrun      = bus.rd_req & ~rd_avail;

`ifdef PINGPONG_BANK_CTRL_STATS_EN
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  // Burst counters wrap; the drop counter sticks at all-ones
  always_comb begin
    stat_wr_d   = stat_wr_q;
    stat_rd_d   = stat_rd_q;
    stat_drop_d = stat_drop_q;
    if (wr_burst_done_q) begin
      stat_wr_d = stat_wr_q + 16'd1;
    end else begin
      stat_wr_d = stat_wr_q;
    end
    if (rd_burst_done_q) begin
      stat_rd_d = stat_rd_q + 16'd1;
    end else begin
      stat_rd_d = stat_rd_q;
    end
    if (bus.overflow && (stat_drop_q != 16'hFFFF)) begin
      stat_drop_d = stat_drop_q + 16'd1;
    end else begin
      stat_drop_d = stat_drop_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_q   <= 16'd0;
      stat_rd_q   <= 16'd0;
      stat_drop_q <= 16'd0;
    end else begin
      stat_wr_q   <= stat_wr_d;
      stat_rd_q   <= stat_rd_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_wr_bursts = stat_wr_q;
  assign stat_rd_bursts = stat_rd_q;
  assign stat_drop_cnt  = stat_drop_q;
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl with an external two-bank RAM model
// for the data-ordering run.
module tb_pingpong_bank_ctrl;
  import pingpong_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pingpong_bank_ctrl_if ifc ();

`ifdef PINGPONG_BANK_CTRL_STATS_EN
  logic [15:0] stat_wr_bursts;
  logic [15:0] stat_rd_bursts;
  logic [15:0] stat_drop_cnt;
`endif

  pingpong_bank_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
`ifdef PINGPONG_BANK_CTRL_STATS_EN
    ,
    .stat_wr_bursts (stat_wr_bursts),
    .stat_rd_bursts (stat_rd_bursts),
    .stat_drop_cnt  (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 after the edge; outputs are sampled 4 after the edge.
  task automatic cyc(input logic wv, input logic rr);
    @(posedge clk);
    #1;
    ifc.wr_valid = wv;
    ifc.rd_req   = rr;
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    ifc.wr_valid = 1'b0;
    ifc.rd_req   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [23:0] ram [2][80];
  logic [23:0] dout [2];
  logic [23:0] exp_q [$];
  int          wa [2];
  int          ra [2];

  initial begin
    int n_done;
    int n_dv;
    int n_ovf;
    int n_rd;
    logic [23:0] wdata;
    logic wv;
    logic rr;
    logic ovf_seen;

    ifc.wr_valid = 1'b0;
    ifc.rd_req   = 1'b0;
    #2;
    check_eq("rst_wr_ready", ifc.wr_ready, 1);
    check_eq("rst_rd_avail", ifc.rd_avail, 0);
    check_eq("rst_state", ifc.bank_state, 4'b0000);
    check_eq("rst_regs", {ifc.rd_data_valid, ifc.rd_mux_sel, ifc.wr_burst_done, ifc.rd_burst_done}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: one full bank of writes
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, 1'b0);
      check_eq("t1_wr_en", ifc.wr_bank_en, 2'b01);
      n_done += int'(ifc.wr_burst_done);
      if (i == 79) check_eq("t1_rd_avail_early", ifc.rd_avail, 0);
    end
    cyc(1'b0, 1'b0);
    check_eq("t1_done", ifc.wr_burst_done, 1);
    check_eq("t1_state", ifc.bank_state, 4'b0010);
    check_eq("t1_rd_avail", ifc.rd_avail, 1);
    n_done += int'(ifc.wr_burst_done);
    cyc(1'b0, 1'b0);
    n_done += int'(ifc.wr_burst_done);
    check_eq("t1_done_cnt", n_done, 1);

    // 2: 240 writes, no reads
    do_reset();
    n_ovf = 0;
    for (int i = 0; i < 240; i++) begin
      cyc(1'b1, 1'b0);
      check_eq("t2_wr_en", ifc.wr_bank_en, (i < 80) ? 2'b01 : ((i < 160) ? 2'b10 : 2'b00));
      n_ovf += int'(ifc.overflow);
      if (i == 160) check_eq("t2_wr_ready", ifc.wr_ready, 0);
    end
    cyc(1'b0, 1'b0);
    check_eq("t2_ovf_cnt", n_ovf, 80);
    check_eq("t2_state", ifc.bank_state, 4'b1010);
    check_eq("t2_ovf_idle", ifc.overflow, 0);
`ifdef PINGPONG_BANK_CTRL_STATS_EN
    check_eq("t2_stat_drop", stat_drop_cnt, 80);
    check_eq("t2_stat_wr", stat_wr_bursts, 2);
`endif

    // 3: drain both banks
    n_dv   = 0;
    n_done = 0;
    for (int i = 0; i < 162; i++) begin
      cyc(1'b0, i < 160);
      check_eq("t3_rd_en", ifc.rd_bank_en, (i < 80) ? 2'b01 : ((i < 160) ? 2'b10 : 2'b00));
      if (ifc.rd_data_valid) begin
        check_eq("t3_mux_sel", ifc.rd_mux_sel, (n_dv < 80) ? 1'b0 : 1'b1);
        n_dv++;
      end
      n_done += int'(ifc.rd_burst_done);
    end
    check_eq("t3_dv_cnt", n_dv, 160);
    check_eq("t3_done_cnt", n_done, 2);
    check_eq("t3_state", ifc.bank_state, 4'b0000);
    check_eq("t3_mux_hold", ifc.rd_mux_sel, 1);
`ifdef PINGPONG_BANK_CTRL_STATS_EN
    check_eq("t3_stat_rd", stat_rd_bursts, 2);
`endif
    cyc(1'b0, 1'b1);
    check_eq("t3_underrun", ifc.underrun, 1);
    check_eq("t3_underrun_en", ifc.rd_bank_en, 2'b00);

    // 4: concurrent traffic against the RAM model
    do_reset();
    wa[0] = 0; wa[1] = 0; ra[0] = 0; ra[1] = 0;
    wdata    = 24'h100000;
    ovf_seen = 1'b0;
    n_rd     = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      wv = ($urandom_range(99) < 50) && ifc.wr_ready;
      rr = ($urandom_range(99) < 70) && ifc.rd_avail;
      ifc.wr_valid = wv;
      ifc.rd_req   = rr;
      #3;
      ovf_seen |= ifc.overflow | ifc.underrun;
      if (ifc.rd_data_valid) begin
        if (exp_q.size() == 0) check_eq("t4_spurious_rdv", 1, 0);
        else check_eq("t4_data", dout[ifc.rd_mux_sel], exp_q.pop_front());
        n_rd++;
      end
      check_eq("t4_rd_en", ifc.rd_bank_en != 2'b00, rr);
      for (int b = 0; b < 2; b++) begin
        if (ifc.rd_bank_en[b]) begin
          dout[b] = ram[b][ra[b]];
          ra[b]   = (ra[b] + 1) % 80;
        end
      end
      check_eq("t4_wr_en", ifc.wr_bank_en != 2'b00, wv);
      for (int b = 0; b < 2; b++) begin
        if (ifc.wr_bank_en[b]) begin
          ram[b][wa[b]] = wdata;
          wa[b]         = (wa[b] + 1) % 80;
          exp_q.push_back(wdata);
          wdata++;
        end
      end
    end
    check_eq("t4_no_ovf_unr", ovf_seen, 0);
    check_eq("t4_reads_seen", n_rd > 200, 1);

    // 5: last read of bank0 coincides with last write of bank1
    do_reset();
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 79; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check_eq("t5_wr_en", ifc.wr_bank_en, 2'b10);
    check_eq("t5_rd_en", ifc.rd_bank_en, 2'b01);
    cyc(1'b0, 1'b0);
    check_eq("t5_done", {ifc.wr_burst_done, ifc.rd_burst_done}, 2'b11);
    check_eq("t5_state", ifc.bank_state, 4'b1000);
    cyc(1'b1, 1'b1);
    check_eq("t5_wr_sel0", ifc.wr_bank_en, 2'b01);
    check_eq("t5_rd_sel1", ifc.rd_bank_en, 2'b10);

    // 6: async reset mid-burst
    do_reset();
    for (int i = 0; i < 37; i++) cyc(1'b1, 1'b0);
    ifc.wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("t6_state", ifc.bank_state, 4'b0000);
    check_eq("t6_wr_ready", ifc.wr_ready, 1);
    check_eq("t6_no_done", ifc.wr_burst_done, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, 1'b0);
      check_eq("t6_wr_en", ifc.wr_bank_en, 2'b01);
      n_done += int'(ifc.wr_burst_done);
    end
    check_eq("t6_no_early_done", n_done, 0);
    cyc(1'b0, 1'b0);
    check_eq("t6_done", ifc.wr_burst_done, 1);
    check_eq("t6_state_full", ifc.bank_state, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
